// File: rtl/mips_store_checker.sv
// rtl/mips_store_checker.sv - in-order store monitor for the mips external-memory bus
// Compares each memwrite cycle against a loaded address/data table within a cycle budget.
module mips_store_checker #(
    parameter int WIDTH   = 32,
    parameter int NEXP    = 8,
    parameter int IW      = 3,
    parameter int CW      = 16,
    parameter int TIMEOUT = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_adr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [IW:0]      cfg_num,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [IW:0]      store_cnt,
    output logic [CW-1:0]    cycle_cnt,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] tab_adr  [NEXP];
    logic [WIDTH-1:0] tab_data [NEXP];
    logic [IW:0]      num;
    logic             ptr_ok, hit, last, tmo;

    // Table survives reset so a program can be re-run without reloading.
    always_ff @(posedge clk) begin
        if (cfg_we && state != RUN && {1'b0, cfg_idx} < (IW+1)'(NEXP)) begin
            tab_adr[cfg_idx]  <= cfg_adr;
            tab_data[cfg_idx] <= cfg_data;
        end
    end

    // store_cnt doubles as the table pointer: both advance only on a match.
    assign ptr_ok = store_cnt < (IW+1)'(NEXP);
    assign hit    = ptr_ok && adr == tab_adr[store_cnt[IW-1:0]]
                           && writedata == tab_data[store_cnt[IW-1:0]];
    assign last   = store_cnt == num - (IW+1)'(1);
    assign tmo    = cycle_cnt == CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = (cfg_num == '0) ? PASS : RUN;
        end else if (state == RUN) begin
            if (memwrite) begin
                if (!hit)      state_nx = FAIL;
                else if (last) state_nx = PASS;
            end else if (tmo) begin
                state_nx = FAIL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            num       <= '0;
            store_cnt <= '0;
            cycle_cnt <= '0;
            err_code  <= 2'd0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else if (start) begin
            num       <= cfg_num;
            store_cnt <= '0;
            cycle_cnt <= '0;
            err_code  <= 2'd0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else if (state == RUN) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CW'(1);
            if (memwrite) begin
                if (hit) begin
                    store_cnt <= store_cnt + (IW+1)'(1);
                end else begin
                    err_code  <= 2'd1;
                    fail_adr  <= adr;
                    fail_data <= writedata;
                end
            end else if (tmo) begin
                err_code <= 2'd2;
            end
        end
    end

    assign busy = state == RUN;
    assign pass = state == PASS;
    assign fail = state == FAIL;
    assign done = pass | fail;

endmodule

// File: tb/tb_mips_store_checker.sv
// tb/tb_mips_store_checker.sv - directed self-checking bench for mips_store_checker
module tb_mips_store_checker;

    localparam int WIDTH = 32;
    localparam int IW    = 3;
    localparam int CW    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             memwrite = 1'b0;
    logic [WIDTH-1:0] adr = '0;
    logic [WIDTH-1:0] writedata = '0;
    logic             cfg_we = 1'b0;
    logic [IW-1:0]    cfg_idx = '0;
    logic [WIDTH-1:0] cfg_adr = '0;
    logic [WIDTH-1:0] cfg_data = '0;
    logic [IW:0]      cfg_num = '0;
    logic             start = 1'b0;
    logic             busy, done, pass, fail;
    logic [1:0]       err_code;
    logic [IW:0]      store_cnt;
    logic [CW-1:0]    cycle_cnt;
    logic [WIDTH-1:0] fail_adr, fail_data;

    int ncmp = 0;
    int nerr = 0;

    mips_store_checker #(.WIDTH(WIDTH), .NEXP(8), .IW(IW), .CW(CW), .TIMEOUT(25)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_num(cfg_num), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .err_code(err_code), .store_cnt(store_cnt), .cycle_cnt(cycle_cnt),
        .fail_adr(fail_adr), .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [IW-1:0] i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        cfg_we = 1'b1; cfg_idx = i; cfg_adr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input logic [IW:0] n);
        start = 1'b1; cfg_num = n;
        step();
        start = 1'b0;
    endtask

    task automatic store(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        memwrite = 1'b1; adr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        ncmp++; if ({busy, done, pass, fail} !== 4'b0000) begin nerr++; $display("FAIL reset_flags got %b want 0000", {busy, done, pass, fail}); end
        ncmp++; if (err_code !== 2'd0) begin nerr++; $display("FAIL reset_err got %0d want 0", err_code); end
        ncmp++; if (store_cnt !== 4'd0 || cycle_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d/%0d want 0/0", store_cnt, cycle_cnt); end
        ncmp++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin nerr++; $display("FAIL reset_faildiag got %h/%h want 0/0", fail_adr, fail_data); end
    endtask

    task automatic test_single();
        load(3'd0, 32'd255, 32'd210);
        do_start(4'd1);
        ncmp++; if (busy !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL single_busy got busy=%b done=%b want 1/0", busy, done); end
        idle(6);
        store(32'd255, 32'd210);
        ncmp++; if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL single_pass got b/d/p/f=%b want 0110", {busy, done, pass, fail}); end
        ncmp++; if (store_cnt !== 4'd1) begin nerr++; $display("FAIL single_store_cnt got %0d want 1", store_cnt); end
        ncmp++; if (cycle_cnt !== 16'd7) begin nerr++; $display("FAIL single_cycle_cnt got %0d want 7", cycle_cnt); end
        ncmp++; if (err_code !== 2'd0) begin nerr++; $display("FAIL single_err got %0d want 0", err_code); end
        store(32'd1, 32'd1);
        idle(3);
        ncmp++; if (pass !== 1'b1 || store_cnt !== 4'd1 || cycle_cnt !== 16'd7) begin nerr++; $display("FAIL single_hold got pass=%b cnt=%0d cyc=%0d want 1/1/7", pass, store_cnt, cycle_cnt); end
    endtask

    task automatic test_three();
        load(3'd0, 32'h10, 32'd1);
        load(3'd1, 32'h14, 32'd2);
        load(3'd2, 32'h18, 32'd3);
        do_start(4'd3);
        idle(2); store(32'h10, 32'd1);
        idle(5); store(32'h14, 32'd2);
        ncmp++; if (busy !== 1'b1 || store_cnt !== 4'd2) begin nerr++; $display("FAIL three_mid got busy=%b cnt=%0d want 1/2", busy, store_cnt); end
        idle(10); store(32'h18, 32'd3);
        ncmp++; if (pass !== 1'b1 || store_cnt !== 4'd3 || cycle_cnt !== 16'd20) begin nerr++; $display("FAIL three_pass got pass=%b cnt=%0d cyc=%0d want 1/3/20", pass, store_cnt, cycle_cnt); end
        do_start(4'd3);
        idle(2); store(32'h10, 32'd1);
        idle(5); store(32'h14, 32'd5);
        ncmp++; if (fail !== 1'b1 || pass !== 1'b0 || err_code !== 2'd1) begin nerr++; $display("FAIL three_mismatch got fail=%b err=%0d want 1/1", fail, err_code); end
        ncmp++; if (fail_adr !== 32'h14 || fail_data !== 32'd5) begin nerr++; $display("FAIL three_diag got %h/%h want 14/5", fail_adr, fail_data); end
        ncmp++; if (store_cnt !== 4'd1 || cycle_cnt !== 16'd9) begin nerr++; $display("FAIL three_mis_cnt got %0d/%0d want 1/9", store_cnt, cycle_cnt); end
    endtask

    task automatic test_timeout();
        do_start(4'd3);
        idle(24);
        ncmp++; if (busy !== 1'b1 || cycle_cnt !== 16'd24) begin nerr++; $display("FAIL tmo_before got busy=%b cyc=%0d want 1/24", busy, cycle_cnt); end
        step();
        ncmp++; if (fail !== 1'b1 || err_code !== 2'd2 || cycle_cnt !== 16'd25) begin nerr++; $display("FAIL tmo_fail got fail=%b err=%0d cyc=%0d want 1/2/25", fail, err_code, cycle_cnt); end
        ncmp++; if (fail_adr !== 32'd0 || fail_data !== 32'd0) begin nerr++; $display("FAIL tmo_diag got %h/%h want 0/0", fail_adr, fail_data); end
        idle(3);
        ncmp++; if (cycle_cnt !== 16'd25 || fail !== 1'b1) begin nerr++; $display("FAIL tmo_hold got cyc=%0d fail=%b want 25/1", cycle_cnt, fail); end
        do_start(4'd1);
        idle(24); store(32'h10, 32'd1);
        ncmp++; if (pass !== 1'b1 || err_code !== 2'd0 || cycle_cnt !== 16'd25) begin nerr++; $display("FAIL tmo_last_store got pass=%b err=%0d cyc=%0d want 1/0/25", pass, err_code, cycle_cnt); end
        do_start(4'd1);
        idle(24); store(32'h10, 32'd9);
        ncmp++; if (fail !== 1'b1 || err_code !== 2'd1 || fail_data !== 32'd9) begin nerr++; $display("FAIL tmo_bad_store got fail=%b err=%0d data=%0d want 1/1/9", fail, err_code, fail_data); end
    endtask

    task automatic test_cfg_locked();
        do_start(4'd1);
        load(3'd0, 32'd1, 32'd1);
        store(32'h10, 32'd1);
        ncmp++; if (pass !== 1'b1 || cycle_cnt !== 16'd2) begin nerr++; $display("FAIL cfg_run_ignored got pass=%b cyc=%0d want 1/2", pass, cycle_cnt); end
        do_start(4'd0);
        ncmp++; if ({busy, done, pass, fail} !== 4'b0110 || store_cnt !== 4'd0) begin nerr++; $display("FAIL num_zero got b/d/p/f=%b cnt=%0d want 0110/0", {busy, done, pass, fail}, store_cnt); end
    endtask

    task automatic test_reset_mid();
        do_start(4'd3);
        idle(2); store(32'h10, 32'd1);
        idle(1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        ncmp++; if ({busy, done, pass, fail} !== 4'b0000 || store_cnt !== 4'd0 || cycle_cnt !== 16'd0) begin nerr++; $display("FAIL reset_mid got flags=%b cnt=%0d cyc=%0d want 0000/0/0", {busy, done, pass, fail}, store_cnt, cycle_cnt); end
    endtask

    task automatic test_restart();
        do_start(4'd3);
        store(32'h10, 32'd1);
        ncmp++; if (store_cnt !== 4'd1) begin nerr++; $display("FAIL restart_pre got cnt=%0d want 1", store_cnt); end
        idle(2);
        do_start(4'd3);
        ncmp++; if (busy !== 1'b1 || store_cnt !== 4'd0 || cycle_cnt !== 16'd0) begin nerr++; $display("FAIL restart_clear got busy=%b cnt=%0d cyc=%0d want 1/0/0", busy, store_cnt, cycle_cnt); end
        store(32'h10, 32'd1);
        ncmp++; if (busy !== 1'b1 || store_cnt !== 4'd1 || fail !== 1'b0) begin nerr++; $display("FAIL restart_first got busy=%b cnt=%0d fail=%b want 1/1/0", busy, store_cnt, fail); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_timeout();
        test_cfg_locked();
        test_reset_mid();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
